// File: rtl/banked_regfile_pkg.sv
// Shared constants for the banked integer/float register file.
// Bank select encoding, default geometry and the hard-wired zero register index.
package regfile_pkg;
  localparam logic BANK_INT  = 1'b0;
  localparam logic BANK_FP   = 1'b1;
  localparam int   DEF_XLEN  = 32;
  localparam int   DEF_DEPTH = 32;
  localparam int   ZERO_REG  = 0;
endpackage

// File: rtl/banked_regfile_if.sv
// Decode/writeback-facing bundle of the banked register file: read ports, write port, reserve port.
// Master drives requests (decode/writeback/bench); slave is the register file.
interface banked_regfile_if #(
  parameter int XLEN   = regfile_pkg::DEF_XLEN,
  parameter int DEPTH  = regfile_pkg::DEF_DEPTH,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD-1:0]      rd_float;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wr_en;
  logic                   wr_float;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   rsv_en;
  logic                   rsv_float;
  logic [AW-1:0]          rsv_addr;

  modport master (
    output rd_en, rd_float, rd_addr, wr_en, wr_float, wr_addr, wr_data,
           rsv_en, rsv_float, rsv_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_float, rd_addr, wr_en, wr_float, wr_addr, wr_data,
           rsv_en, rsv_float, rsv_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/banked_regfile_bank.sv
// One register bank: DEPTH x XLEN storage plus busy scoreboard; state visible combinationally.
// PROTECT_ZERO=1 makes entry 0 a constant zero that is never written nor reserved.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int DEPTH        = DEF_DEPTH,
  parameter bit PROTECT_ZERO = 1'b0,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [AW-1:0]              i_wr_addr,
  input  logic [XLEN-1:0]            i_wr_data,
  input  logic                       i_rsv_en,
  input  logic [AW-1:0]              i_rsv_addr,
  output logic [DEPTH-1:0][XLEN-1:0] o_regs,
  output logic [DEPTH-1:0]           o_busy
);
  logic [DEPTH-1:0][XLEN-1:0] r_regs;
  logic [DEPTH-1:0]           r_busy;
  logic                       w_wr_ok;
  logic                       w_rsv_ok;

  assign w_wr_ok  = i_wr_en  && !(PROTECT_ZERO && (i_wr_addr  == AW'(ZERO_REG)));
  assign w_rsv_ok = i_rsv_en && !(PROTECT_ZERO && (i_rsv_addr == AW'(ZERO_REG)));

  // Reservation is applied after the write so it wins on a shared target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[i_wr_addr] <= i_wr_data;
        r_busy[i_wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy[i_rsv_addr] <= 1'b1;
      end
    end
  end

  assign o_regs = r_regs;
  assign o_busy = r_busy;
endmodule

// File: rtl/banked_regfile.sv
// Two-bank (int/float) register file, NUM_RD registered read ports, 1-cycle read latency, busy scoreboard.
// Optional same-cycle write-to-read forwarding when FWD_BYPASS_EN is defined; no backpressure.
module banked_regfile
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  banked_regfile_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][XLEN-1:0]  w_int_regs;
  logic [DEPTH-1:0][XLEN-1:0]  w_fp_regs;
  logic [DEPTH-1:0]            w_int_busy;
  logic [DEPTH-1:0]            w_fp_busy;
  logic [AW-1:0]               w_addr [NUM_RD];
  logic [NUM_RD-1:0][XLEN-1:0] w_val;
  logic [NUM_RD-1:0]           w_bsy;
  logic [NUM_RD-1:0][XLEN-1:0] r_rd_data;
  logic [NUM_RD-1:0]           r_rd_busy;

  regfile_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .PROTECT_ZERO(1'b1)) u_int_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (bus.wr_en && (bus.wr_float == BANK_INT)),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rsv_en  (bus.rsv_en && (bus.rsv_float == BANK_INT)),
    .i_rsv_addr(bus.rsv_addr),
    .o_regs    (w_int_regs),
    .o_busy    (w_int_busy)
  );

  regfile_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .PROTECT_ZERO(1'b0)) u_fp_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (bus.wr_en && (bus.wr_float == BANK_FP)),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rsv_en  (bus.rsv_en && (bus.rsv_float == BANK_FP)),
    .i_rsv_addr(bus.rsv_addr),
    .o_regs    (w_fp_regs),
    .o_busy    (w_fp_busy)
  );

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_addr[p] = bus.rd_addr[p*AW +: AW];
      if (bus.rd_float[p] == BANK_FP) begin
        w_val[p] = w_fp_regs[w_addr[p]];
        w_bsy[p] = w_fp_busy[w_addr[p]];
      end else begin
        w_val[p] = w_int_regs[w_addr[p]];
        w_bsy[p] = w_int_busy[w_addr[p]];
      end
`ifdef FWD_BYPASS_EN
      // Forward the in-flight write; integer r0 stays hard zero.
      if (bus.wr_en && (bus.wr_float == bus.rd_float[p]) && (bus.wr_addr == w_addr[p]) &&
          !((bus.rd_float[p] == BANK_INT) && (w_addr[p] == AW'(ZERO_REG)))) begin
        w_val[p] = bus.wr_data;
        w_bsy[p] = bus.rsv_en && (bus.rsv_float == bus.rd_float[p]) &&
                   (bus.rsv_addr == w_addr[p]);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.rd_en[p]) begin
          r_rd_data[p] <= w_val[p];
          r_rd_busy[p] <= w_bsy[p];
        end
      end
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.rd_busy = r_rd_busy;
endmodule

// File: tb/tb_banked_regfile.sv
// Bench for banked_regfile: directed vector table, async-reset sequence, randomized run vs. array model.
module tb_banked_regfile;
  localparam int XLEN = 32, DEPTH = 32, NUM_RD = 2, AW = 5;
`ifdef FWD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  banked_regfile_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) bus ();
  banked_regfile #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd_en;
    logic [1:0]  rd_float;
    logic [4:0]  a0, a1;
    logic        wr_en, wr_float;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rsv_en, rsv_float;
    logic [4:0]  ra;
    logic [31:0] e0, e1;
    logic        eb0, eb1;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [31:0] m_int [DEPTH];
  logic [31:0] m_fp  [DEPTH];
  bit          b_int [DEPTH];
  bit          b_fp  [DEPTH];
  logic [31:0] exp_d [NUM_RD];
  bit          exp_b [NUM_RD];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] en, input logic [1:0] fl, input int a0, input int a1,
                              input bit we, input bit wf, input int wa, input logic [31:0] wd,
                              input bit re, input bit rf, input int ra,
                              input logic [31:0] e0, input logic [31:0] e1, input bit eb0, input bit eb1);
    vec_t v;
    v.rd_en = en; v.rd_float = fl; v.a0 = 5'(a0); v.a1 = 5'(a1);
    v.wr_en = we; v.wr_float = wf; v.wa = 5'(wa); v.wd = wd;
    v.rsv_en = re; v.rsv_float = rf; v.ra = 5'(ra);
    v.e0 = e0; v.e1 = e1; v.eb0 = eb0; v.eb1 = eb1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.rd_en    = v.rd_en;
    bus.rd_float = v.rd_float;
    bus.rd_addr  = {v.a1, v.a0};
    bus.wr_en    = v.wr_en;
    bus.wr_float = v.wr_float;
    bus.wr_addr  = v.wa;
    bus.wr_data  = v.wd;
    bus.rsv_en   = v.rsv_en;
    bus.rsv_float = v.rsv_float;
    bus.rsv_addr = v.ra;
  endtask

  task automatic idle();
    drive(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0));
  endtask

  task automatic check_ports(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input bit eb0, input bit eb1);
    check({tag, " d0"}, bus.rd_data[31:0], e0);
    check({tag, " d1"}, bus.rd_data[63:32], e1);
    check({tag, " b0"}, 32'(bus.rd_busy[0]), 32'(eb0));
    check({tag, " b1"}, 32'(bus.rd_busy[1]), 32'(eb1));
  endtask

  function automatic logic [31:0] mget(input bit f, input int a);
    if (f) return m_fp[a];
    return (a == 0) ? 32'h0 : m_int[a];
  endfunction

  function automatic bit bget(input bit f, input int a);
    if (f) return b_fp[a];
    return (a == 0) ? 1'b0 : b_int[a];
  endfunction

  initial begin
    idle();
    // Directed vectors: each entry lists inputs for one edge and both ports' outputs after it
    vecs.push_back(mk(2'b11, 2'b10, 5, 5, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 0, 3, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(2'b11, 2'b10, 3, 3, 0, 0, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 32'h1234, 1, 0, 0, 32'hDEADBEEF, 32'h0, 0, 0));
    vecs.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 32'h1234, 1, 1, 0, 32'h0, 32'h0, 0, 0));
    vecs.push_back(mk(2'b11, 2'b11, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h1234, 32'h1234, 1, 1));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 32'h0, 1, 1, 7, 32'h1234, 32'h1234, 1, 1));
    vecs.push_back(mk(2'b01, 2'b01, 7, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h1234, 1, 1));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 32'h0, 32'h1234, 1, 1));
    vecs.push_back(mk(2'b01, 2'b01, 7, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'hA5A5A5A5, 32'h1234, 0, 1));
    vecs.push_back(mk(2'b10, 2'b00, 0, 9, 1, 0, 9, 32'h55, 0, 0, 0,
                      32'hA5A5A5A5, BYP ? 32'h55 : 32'h0, 0, 0));
    vecs.push_back(mk(2'b01, 2'b00, 9, 0, 0, 0, 0, 32'h0, 0, 0, 0,
                      32'h55, BYP ? 32'h55 : 32'h0, 0, 0));
    vecs.push_back(mk(2'b00, 2'b00, 0, 0, 1, 0, 4, 32'h77, 1, 0, 4, 32'h55, BYP ? 32'h55 : 32'h0, 0, 0));
    vecs.push_back(mk(2'b11, 2'b00, 4, 4, 0, 0, 0, 32'h0, 0, 0, 0, 32'h77, 32'h77, 1, 1));

    repeat (2) @(posedge clk);
    #1 check_ports("in_reset", 32'h0, 32'h0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1 check_ports($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].eb0, vecs[i].eb1);
    end

    // Async reset mid-stream with a write and reservation pending
    drive(mk(2'b11, 2'b00, 4, 4, 1, 0, 4, 32'h99, 1, 1, 7, 32'h0, 32'h0, 0, 0));
    #2 rst_n = 1'b0;
    #1 check_ports("async_rst", 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1 idle();
    @(negedge clk) rst_n = 1'b1;
    drive(mk(2'b11, 2'b01, 7, 4, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0));
    @(posedge clk);
    #1 check_ports("post_rst", 32'h0, 32'h0, 0, 0);

    // Randomized run against the array model; state is all-zero after the reset above
    for (int a = 0; a < DEPTH; a++) begin
      m_int[a] = '0; m_fp[a] = '0; b_int[a] = 0; b_fp[a] = 0;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      exp_d[p] = '0; exp_b[p] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      int   ra [NUM_RD];
      bit   rf [NUM_RD];
      v = mk(2'($urandom), 2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
             ($urandom_range(0, 2) != 0), 1'($urandom), $urandom_range(0, 7), $urandom,
             ($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(0, 7),
             32'h0, 32'h0, 0, 0);
      ra[0] = int'(v.a0); ra[1] = int'(v.a1);
      for (int p = 0; p < NUM_RD; p++) begin
        rf[p] = v.rd_float[p];
        if (v.rd_en[p]) begin
          exp_d[p] = mget(rf[p], ra[p]);
          exp_b[p] = bget(rf[p], ra[p]);
          if (BYP && v.wr_en && v.wr_float == rf[p] && int'(v.wa) == ra[p] &&
              !(!rf[p] && ra[p] == 0)) begin
            exp_d[p] = v.wd;
            exp_b[p] = v.rsv_en && v.rsv_float == rf[p] && int'(v.ra) == ra[p];
          end
        end
      end
      if (v.wr_en) begin
        if (v.wr_float) begin
          m_fp[v.wa] = v.wd; b_fp[v.wa] = 0;
        end else if (v.wa != 0) begin
          m_int[v.wa] = v.wd; b_int[v.wa] = 0;
        end
      end
      if (v.rsv_en) begin
        if (v.rsv_float) b_fp[v.ra] = 1;
        else if (v.ra != 0) b_int[v.ra] = 1;
      end
      drive(v);
      @(posedge clk);
      #1 check_ports($sformatf("rnd%0d", n), exp_d[0], exp_d[1], exp_b[0], exp_b[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
